regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised general-purpose register file for the NPC core, replacing the single-read-port file. It has two combinational read ports, one synchronous write port and an asynchronous clear of all registers on reset. A per-register busy scoreboard lets the decode stage detect read-after-write hazards against in-flight writes. A fixed a0 tap and a selectable debug read port feed the simulation environment (ebreak return value, difftest register dump).

## Interface
Parameters:
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 64, register width in bits
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never busy

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- wen  in  1  write enable (writeback)
- waddr  in  ADDR_WIDTH  write index
- wdata  in  DATA_WIDTH  write data
- raddr1 / raddr2  in  ADDR_WIDTH  read indices
- rdata1 / rdata2  out  DATA_WIDTH  read data, combinational
- busy1 / busy2  out  1  pending write exists for raddr1 / raddr2
- iss_valid  in  1  instruction with destination issued this cycle
- iss_rd  in  ADDR_WIDTH  destination index of issued instruction
- flush  in  1  clear every busy bit (pipeline flush)
- dbg_addr  in  ADDR_WIDTH  debug read index
- dbg_data  out  DATA_WIDTH  stored value at dbg_addr, never bypassed
- a0_val  out  DATA_WIDTH  stored value of register 10

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH registers plus 2**ADDR_WIDTH busy bits.
- Write: on a rising edge with wen=1, rf[waddr] <= wdata. With ZERO_REG=1 and waddr=0, no write occurs.
- Read: rdataN = rf[raddrN]. With ZERO_REG=1 and raddrN=0, rdataN is 0 regardless of contents.
- Scoreboard, per index i, at each edge in priority order:
  - flush=1: all bits clear. flush beats any same-cycle issue.
  - iss_valid=1 and iss_rd=i: bit i sets. A set beats a same-cycle writeback clear of the same i.
  - wen=1 and waddr=i: bit i clears.
  - Otherwise bit i holds.
- Single-bit scoreboard: the issue stage issues at most one outstanding write per register. Re-issuing to a busy register leaves the bit set; the first writeback clears it.
- busyN = busy[raddrN], forced 0 for index 0 when ZERO_REG=1. Issue to index 0 is ignored when ZERO_REG=1.
- Widths: DATA_WIDTH bits everywhere, no extension or truncation; indices are used unsigned.

## Timing
- Reset: asserting rst clears all registers, busy bits and outputs immediately, independent of clk. While rst=1, rdata1, rdata2, dbg_data and a0_val read 0 and busy1/busy2 read 0. On rst deassertion the first active edge performs normal updates.
- Reset during an outstanding write clears the scoreboard; the later writeback still writes the register, and clearing an already-clear bit is harmless.
- Write latency: the value is visible at the stored-value outputs (dbg_data, a0_val, non-bypassed reads) one cycle after the wen edge.
- Scoreboard latency: busy rises the cycle after the issue edge and falls the cycle after the writeback edge, or the same cycle when bypass is enabled (see Configuration).
- Read ports and debug port are purely combinational and have no handshake.

## Configuration
- RF_BYPASS_EN defined:
  - When wen=1 and waddr=raddrN (and not index 0 with ZERO_REG=1), rdataN = wdata and busyN = 0 in the same cycle.
  - dbg_data and a0_val are never bypassed.
- RF_BYPASS_EN undefined:
  - rdataN and busyN reflect stored state only.
  - A read that coincides with a write returns the old value and the old busy state.

## Test plan
- Reset then read: pulse rst mid-cycle after writing 0xDEAD to x5 -> rdata1 for raddr1=5 reads 0 immediately; all busy outputs 0.
- Basic write/read: write 0x1234_5678_9ABC_DEF0 to x10 -> next cycle rdata2 (raddr2=10), a0_val and dbg_data (dbg_addr=10) all equal it.
- Zero register: write 0xFFFF to x0, issue to x0 -> rdata1 (raddr1=0) = 0 and busy1 = 0 on all following cycles.
- Scoreboard:
  - Issue x7, then the following cycle both writeback x7 and issue x7 -> busy1 (raddr1=7) stays 1.
  - Next cycle, writeback x7 only -> busy1 = 0 after that edge.
  - Issue x3 and assert flush in the same cycle -> busy for x3 stays 0.
- Bypass: raddr1=4, wen=1, waddr=4, wdata=0xAA in the same cycle:
  - With RF_BYPASS_EN -> rdata1 = 0xAA and busy1 = 0 that cycle.
  - Without RF_BYPASS_EN -> rdata1 = old value that cycle, 0xAA the next cycle.
- Parameter sweep: ADDR_WIDTH=4, DATA_WIDTH=32 -> write 0xCAFEBABE to x15, read back on both ports; index 15 behaves like every other index.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port and a busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining RF_BYPASS_EN.
module regfile_sb #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic                  busy1,
    output logic                  busy2,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data,
    output logic [DATA_WIDTH-1:0] a0_val
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam int unsigned A0Idx = 10;

    logic [DATA_WIDTH-1:0] rf_q [Depth];
    logic [Depth-1:0]      busy_q;
    logic [Depth-1:0]      busy_d;
    logic                  wr_en;
    logic                  iss_en;

    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    assign wr_en  = wen && !is_zero(waddr);
    assign iss_en = iss_valid && !is_zero(iss_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(Depth); i++) begin
                rf_q[i] <= '0;
            end
        end else if (wr_en) begin
            rf_q[waddr] <= wdata;
        end
    end

    // Priority: flush > issue set > writeback clear.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[waddr] = 1'b0;
        end
        if (iss_en) begin
            busy_d[iss_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        busy1  = 1'b0;
        busy2  = 1'b0;
        // Gate on rst so the bypass path cannot leak wdata while in reset.
        if (!rst) begin
            if (!is_zero(raddr1)) begin
                rdata1 = rf_q[raddr1];
                busy1  = busy_q[raddr1];
            end
            if (!is_zero(raddr2)) begin
                rdata2 = rf_q[raddr2];
                busy2  = busy_q[raddr2];
            end
`ifdef RF_BYPASS_EN
            if (wr_en && (waddr == raddr1)) begin
                rdata1 = wdata;
                busy1  = 1'b0;
            end
            if (wr_en && (waddr == raddr2)) begin
                rdata2 = wdata;
                busy2  = 1'b0;
            end
`else
`endif
        end
    end

    assign dbg_data = rst ? '0 : rf_q[dbg_addr];

    generate
        if (Depth > A0Idx) begin : g_a0
            localparam logic [ADDR_WIDTH-1:0] A0Addr = A0Idx[ADDR_WIDTH-1:0];
            assign a0_val = rst ? '0 : rf_q[A0Addr];
        end else begin : g_no_a0
            assign a0_val = '0;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: vector table with expectation queue, plus
// hand sequences for reset, bypass and a 16x32 parameter variant.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wen = 1'b0;
    logic [4:0]  waddr = '0;
    logic [63:0] wdata = '0;
    logic [4:0]  raddr1 = '0;
    logic [4:0]  raddr2 = '0;
    logic [63:0] rdata1, rdata2;
    logic        busy1, busy2;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic        flush = 1'b0;
    logic [4:0]  dbg_addr = '0;
    logic [63:0] dbg_data, a0_val;

    logic        wen2 = 1'b0;
    logic [3:0]  waddr2 = '0;
    logic [31:0] wdata2 = '0;
    logic [3:0]  raddr1_2 = '0;
    logic [3:0]  raddr2_2 = '0;
    logic [31:0] rdata1_2, rdata2_2;
    logic        busy1_2, busy2_2;
    logic        iss2 = 1'b0;
    logic [3:0]  iss_rd2 = '0;
    logic [3:0]  dbg_addr2 = '0;
    logic [31:0] dbg_data2, a0_val2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_sb u_dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .busy1(busy1), .busy2(busy2), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .flush(flush), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .a0_val(a0_val)
    );

    regfile_sb #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .ZERO_REG(1)) u_dut2 (
        .clk(clk), .rst(rst), .wen(wen2), .waddr(waddr2), .wdata(wdata2),
        .raddr1(raddr1_2), .raddr2(raddr2_2), .rdata1(rdata1_2), .rdata2(rdata2_2),
        .busy1(busy1_2), .busy2(busy2_2), .iss_valid(iss2), .iss_rd(iss_rd2),
        .flush(1'b0), .dbg_addr(dbg_addr2), .dbg_data(dbg_data2), .a0_val(a0_val2)
    );

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [63:0] wdata;
        logic        iss;
        logic [4:0]  iss_rd;
        logic        flush;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [63:0] e1;
        logic [63:0] e2;
        logic        eb1;
        logic        eb2;
        logic [63:0] ea0;
        logic [63:0] edbg;
    } vec_t;

    typedef struct {
        logic [63:0] e1;
        logic [63:0] e2;
        logic        eb1;
        logic        eb2;
        logic [63:0] ea0;
        logic [63:0] edbg;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        exp_t e;
        exp_t got;
        string tag;
        @(negedge clk);
        wen = v.wen; waddr = v.waddr; wdata = v.wdata;
        iss_valid = v.iss; iss_rd = v.iss_rd; flush = v.flush;
        raddr1 = v.r1; raddr2 = v.r2; dbg_addr = v.r1;
        e = '{v.e1, v.e2, v.eb1, v.eb2, v.ea0, v.edbg};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        wen = 1'b0; iss_valid = 1'b0; flush = 1'b0;
        #1;
        got = exp_q.pop_front();
        tag = $sformatf("vec%0d", idx);
        check({tag, ".rdata1"}, rdata1, got.e1);
        check({tag, ".rdata2"}, rdata2, got.e2);
        check({tag, ".busy1"}, {63'd0, busy1}, {63'd0, got.eb1});
        check({tag, ".busy2"}, {63'd0, busy2}, {63'd0, got.eb2});
        check({tag, ".a0_val"}, a0_val, got.ea0);
        check({tag, ".dbg_data"}, dbg_data, got.edbg);
    endtask

    localparam logic [63:0] V10  = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        //         wen wa  wdata     iss ird fl  r1  r2  e1     e2     b1 b2 a0   dbg
        vecs[0] = '{0, 0,  64'h0,    1,  7,  0,  7,  5,  64'h0, 64'h0, 1, 0, 64'h0, 64'h0};
        vecs[1] = '{1, 7,  64'h77,   1,  7,  0,  7,  7,  64'h77, 64'h77, 1, 1, 64'h0, 64'h77};
        vecs[2] = '{1, 7,  64'h78,   0,  0,  0,  7,  7,  64'h78, 64'h78, 0, 0, 64'h0, 64'h78};
        vecs[3] = '{0, 0,  64'h0,    1,  3,  1,  3,  7,  64'h0, 64'h78, 0, 0, 64'h0, 64'h0};
        vecs[4] = '{1, 0,  64'hFFFF, 1,  0,  0,  0,  0,  64'h0, 64'h0, 0, 0, 64'h0, 64'h0};
        vecs[5] = '{1, 10, V10,      0,  0,  0,  10, 10, V10,   V10,   0, 0, V10,  V10};
        vecs[6] = '{0, 0,  64'h0,    1,  12, 0,  12, 10, 64'h0, V10,   1, 0, V10,  64'h0};
        vecs[7] = '{1, 12, 64'hBEEF, 1,  5,  0,  12, 5,  64'hBEEF, 64'h0, 0, 1, V10, 64'hBEEF};
        vecs[8] = '{0, 0,  64'h0,    0,  0,  1,  5,  12, 64'h0, 64'hBEEF, 0, 0, V10, 64'h0};
        vecs[9] = '{1, 31, ONES,     0,  0,  0,  31, 0,  ONES,  64'h0, 0, 0, V10,  ONES};

        // Power-on reset
        raddr1 = 5'd5; raddr2 = 5'd10; dbg_addr = 5'd10;
        #1 rst = 1'b1;
        #2;
        check("reset.rdata1", rdata1, 64'h0);
        check("reset.a0_val", a0_val, 64'h0);
        check("reset.busy", {62'd0, busy1, busy2}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            apply(i, vecs[i]);
        end

        // Zero register stays 0 and not busy a cycle later
        @(negedge clk);
        raddr1 = 5'd0;
        #1;
        check("zero.rdata1", rdata1, 64'h0);
        check("zero.busy1", {63'd0, busy1}, 64'h0);

        // Asynchronous reset mid-cycle after writing 0xDEAD to x5
        @(negedge clk);
        wen = 1'b1; waddr = 5'd5; wdata = 64'hDEAD;
        iss_valid = 1'b1; iss_rd = 5'd6;
        raddr1 = 5'd5; raddr2 = 5'd6; dbg_addr = 5'd5;
        @(posedge clk);
        #1 wen = 1'b0; iss_valid = 1'b0;
        #1;
        check("prerst.rdata1", rdata1, 64'hDEAD);
        check("prerst.busy2", {63'd0, busy2}, 64'h1);
        #1 rst = 1'b1;
        #1;
        check("midrst.rdata1", rdata1, 64'h0);
        check("midrst.busy2", {63'd0, busy2}, 64'h0);
        check("midrst.dbg_data", dbg_data, 64'h0);
        check("midrst.a0_val", a0_val, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Reset with an outstanding write; the later writeback still lands
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd9; raddr1 = 5'd9;
        @(posedge clk);
        #1 iss_valid = 1'b0;
        #1;
        check("outst.busy1", {63'd0, busy1}, 64'h1);
        #1 rst = 1'b1;
        #1;
        check("outst.rstbusy1", {63'd0, busy1}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        wen = 1'b1; waddr = 5'd9; wdata = 64'h99;
        @(posedge clk);
        #1 wen = 1'b0;
        #1;
        check("outst.rdata1", rdata1, 64'h99);
        check("outst.busy1_after", {63'd0, busy1}, 64'h0);

        // Bypass: x4 holds 0x11 and is busy, then same-cycle write of 0xAA
        @(negedge clk);
        wen = 1'b1; waddr = 5'd4; wdata = 64'h11;
        @(negedge clk);
        wen = 1'b0; iss_valid = 1'b1; iss_rd = 5'd4;
        @(negedge clk);
        iss_valid = 1'b0;
        raddr1 = 5'd4; dbg_addr = 5'd4;
        wen = 1'b1; waddr = 5'd4; wdata = 64'hAA;
        #1;
`ifdef RF_BYPASS_EN
        check("bypass.rdata1", rdata1, 64'hAA);
        check("bypass.busy1", {63'd0, busy1}, 64'h0);
`else
        check("nobypass.rdata1", rdata1, 64'h11);
        check("nobypass.busy1", {63'd0, busy1}, 64'h1);
`endif
        check("bypass.dbg_data", dbg_data, 64'h11);
        @(posedge clk);
        #1 wen = 1'b0;
        #1;
        check("bypass.next_rdata1", rdata1, 64'hAA);
        check("bypass.next_busy1", {63'd0, busy1}, 64'h0);

        // 16 x 32 variant: top index and a0 tap
        @(negedge clk);
        wen2 = 1'b1; waddr2 = 4'd15; wdata2 = 32'hCAFE_BABE;
        raddr1_2 = 4'd15; raddr2_2 = 4'd15; dbg_addr2 = 4'd15;
        @(negedge clk);
        waddr2 = 4'd10; wdata2 = 32'h0BAD_F00D;
        check("p16.rdata1", {32'd0, rdata1_2}, {32'd0, 32'hCAFE_BABE});
        check("p16.rdata2", {32'd0, rdata2_2}, {32'd0, 32'hCAFE_BABE});
        check("p16.dbg_data", {32'd0, dbg_data2}, {32'd0, 32'hCAFE_BABE});
        @(negedge clk);
        wen2 = 1'b0; iss2 = 1'b1; iss_rd2 = 4'd15;
        check("p16.a0_val", {32'd0, a0_val2}, {32'd0, 32'h0BAD_F00D});
        @(negedge clk);
        iss2 = 1'b0;
        check("p16.busy", {62'd0, busy1_2, busy2_2}, 64'h3);
        wen2 = 1'b1; waddr2 = 4'd15; wdata2 = 32'h1;
        @(negedge clk);
        wen2 = 1'b0;
        check("p16.busy_clr", {62'd0, busy1_2, busy2_2}, 64'h0);
        check("p16.rdata1_new", {32'd0, rdata1_2}, 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
